// File: rtl/gpio_axi_lite_slave_if.sv
// gpio_axi_lite_slave_if: AXI-Lite bus bundle between the core master port and the GPIO responder.
interface gpio_axi_lite_slave_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/gpio_axi_lite_slave.sv
// gpio_axi_lite_slave: AXI-Lite LED/button peripheral with debounced buttons and a maskable press interrupt.
module gpio_axi_lite_slave #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ADDR_W          = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  gpio_axi_lite_slave_if.slave       ax,
  output logic [7:0]                 led_o,
  input  logic [3:0]                 btn_i,
  output logic                       irq_o,
  input  logic                       eoi_i
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic              aw_q, w_q, awready_q, wready_q, arready_q, bvalid_q, rvalid_q, wstrb_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [7:0]        wdata_q, led_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [31:0]       rdata_q;
  logic [3:0]        mask_q, status_q, sync1_q, sync_q, stable_q, stable_prev_q;
  logic [CW-1:0]     cnt_q [4];
  logic              aw_hs, w_hs, ar_hs, b_hs, r_hs, commit, we, w_ok, r_ok, wr;
  logic [ADDR_W-1:0] wa;
  logic [7:0]        wd;
  logic [1:0]        wsel, rsel;
  logic [31:0]       rd_val;
  logic [3:0]        w1c, status_d;
  assign aw_hs  = ax.awvalid & awready_q;
  assign w_hs   = ax.wvalid & wready_q;
  assign ar_hs  = ax.arvalid & arready_q;
  assign b_hs   = bvalid_q & ax.bready;
  assign r_hs   = rvalid_q & ax.rready;
  // The completing handshake is used directly so the commit lands on that same edge.
  assign wa     = aw_hs ? ax.awaddr : awaddr_q;
  assign wd     = w_hs ? 8'(ax.wdata) : wdata_q;
  assign we     = w_hs ? |(ax.wstrb & 4'b0001) : wstrb_q;
  assign commit = (aw_q | aw_hs) & (w_q | w_hs);
  assign w_ok   = (wa >> 4) == '0;
  assign wsel   = 2'(wa >> 2);
  assign wr     = commit & w_ok & we;
  assign r_ok   = (ax.araddr >> 4) == '0;
  assign rsel   = 2'(ax.araddr >> 2);
  assign rd_val = !r_ok ? 32'h0 : rsel == 2'd0 ? {24'h0, led_q} : rsel == 2'd1 ? {28'h0, stable_q} :
                  rsel == 2'd2 ? {28'h0, status_q} : {28'h0, mask_q};
  assign w1c      = (wr && wsel == 2'd2) ? wd[3:0] : 4'h0;
  assign status_d = (status_q & ~(w1c | {4{eoi_i}})) | (stable_q & ~stable_prev_q);
  assign ax.awready = awready_q;
  assign ax.wready  = wready_q;
  assign ax.arready = arready_q;
  assign ax.bvalid  = bvalid_q;
  assign ax.bresp   = bresp_q;
  assign ax.rvalid  = rvalid_q;
  assign ax.rdata   = rdata_q;
  assign ax.rresp   = rresp_q;
  assign led_o      = led_q;
  assign irq_o      = |(status_q & mask_q);
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      {aw_q, w_q, awready_q, wready_q, arready_q, bvalid_q, rvalid_q, wstrb_q} <= '0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      led_q         <= '0;
      bresp_q       <= '0;
      rresp_q       <= '0;
      rdata_q       <= '0;
      mask_q        <= '0;
      status_q      <= '0;
      sync1_q       <= '0;
      sync_q        <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      cnt_q         <= '{default: '0};
    end else begin
      awready_q <= aw_hs ? 1'b0 : (b_hs || (!aw_q && !bvalid_q)) ? 1'b1 : awready_q;
      wready_q  <= w_hs ? 1'b0 : (b_hs || (!w_q && !bvalid_q)) ? 1'b1 : wready_q;
      aw_q      <= commit ? 1'b0 : aw_hs ? 1'b1 : aw_q;
      w_q       <= commit ? 1'b0 : w_hs ? 1'b1 : w_q;
      awaddr_q  <= wa;
      wdata_q   <= wd;
      wstrb_q   <= we;
      bvalid_q  <= commit ? 1'b1 : b_hs ? 1'b0 : bvalid_q;
      bresp_q   <= commit ? (w_ok ? 2'b00 : 2'b10) : bresp_q;
      led_q     <= (wr && wsel == 2'd0) ? wd : led_q;
      mask_q    <= (wr && wsel == 2'd3) ? wd[3:0] : mask_q;
      status_q  <= status_d;
      arready_q <= ar_hs ? 1'b0 : (r_hs || !rvalid_q) ? 1'b1 : arready_q;
      rvalid_q  <= ar_hs ? 1'b1 : r_hs ? 1'b0 : rvalid_q;
      rdata_q   <= ar_hs ? rd_val : rdata_q;
      rresp_q   <= ar_hs ? (r_ok ? 2'b00 : 2'b10) : rresp_q;
      sync1_q       <= btn_i;
      sync_q        <= sync1_q;
      stable_prev_q <= stable_q;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]    <= (sync_q[i] != stable_q[i] && cnt_q[i] != CW'(DEBOUNCE_CYCLES - 1)) ? cnt_q[i] + 1'b1 : '0;
        stable_q[i] <= (sync_q[i] != stable_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? sync_q[i] : stable_q[i];
      end
    end
  end
endmodule

// File: doc/gpio_axi_lite_slave.md
# gpio_axi_lite_slave

AXI-Lite responder for the LED/button peripheral. It answers core-issued register reads and writes and drives the board LEDs. It debounces the four push-buttons and raises a single-bit interrupt on a button press. It sits inside the peripheral region, behind the core's AXI-Lite master port; its `irq` feeds one bit of the 32-bit interrupt vector, and the core's `eoi` pulse returns to it.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required before a button change is accepted; legal range ≥ 2.
- `ADDR_W`, 8: width of the local address (byte offset) seen by this block.
- `clk` input 1: single clock domain for all logic.
- `reset` input 1: synchronous, active-high reset.
- `awaddr` input ADDR_W: write address.
- `awvalid` input 1, `awready` output 1: write-address handshake.
- `wdata` input 32, `wstrb` input 4: write data and byte strobes.
- `wvalid` input 1, `wready` output 1: write-data handshake.
- `bresp` output 2, `bvalid` output 1, `bready` input 1: write response.
- `araddr` input ADDR_W: read address.
- `arvalid` input 1, `arready` output 1: read-address handshake.
- `rdata` output 32, `rresp` output 2, `rvalid` output 1, `rready` input 1: read data.
- `led` output 8: LED drive.
- `btn` input 4: raw asynchronous button pins.
- `irq` output 1: level interrupt request.
- `eoi` input 1: one-cycle end-of-interrupt pulse from the core.

## Operation
- Register map (offset = address bits [ADDR_W-1:0]; bits [1:0] ignored):
  - 0x00 LED: RW, bits [7:0].
  - 0x04 BTN: RO, debounced state in bits [3:0].
  - 0x08 IRQ_STATUS: write-1-to-clear (W1C), bits [3:0].
  - 0x0C IRQ_MASK: RW, bits [3:0].
- Unused bits read as 0.
- Offsets 0x10 and above are unmapped:
  - Read: `rdata`=0, `rresp`=2'b10 (SLVERR).
  - Write: data dropped, `bresp`=2'b10.
- Mapped accesses respond with 2'b00 (OKAY).
- Writes take effect only if `wstrb[0]`=1; otherwise the write is dropped but still responds OKAY.
- Write channel:
  - AW and W are accepted independently, in either order or in the same cycle. Each is latched on handshake.
  - `awready` is deasserted once AW is latched, until the response completes; `wready` likewise for W.
  - When both are held, the register update and `bvalid`=1 occur on the same edge.
  - `bvalid` holds until `bready`; neither `awready` nor `wready` reasserts until the cycle after the `bvalid`&&`bready` handshake.
- Read channel:
  - `arready`=1 whenever `rvalid`=0.
  - The AR handshake samples register contents onto `rdata` and sets `rvalid` on the same edge.
  - `rvalid`, `rdata` and `rresp` are held stable until `rready`.
- Read and write channels are independent. A read accepted on the same edge as a write commit returns the pre-write value.
- Button debounce, per bit:
  - Two-flop synchronizer produces `sync`.
  - A counter increments while `sync` ≠ `stable` and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while `sync` ≠ `stable`, `stable` takes `sync` and the counter clears.
- Status set: a 0→1 transition of `stable[i]` (registered edge detect) sets `IRQ_STATUS[i]`.
- Status clear:
  - A write to IRQ_STATUS clears the bits written as 1.
  - An `eoi` pulse clears all four bits.
  - If a set and a clear hit the same bit on the same edge, set wins.
- `irq` = OR of (`IRQ_STATUS` & `IRQ_MASK`), decoded only from flops, so it is glitch-free.

## Timing
- During reset and on the first cycle after it, all of these are 0:
  - `led`, `irq`, `bvalid`, `rvalid`, `rdata`, `bresp`, `rresp`, `awready`, `wready`, `arready`.
  - All registers, counters, `sync` and `stable`.
- Ready signals rise on the first cycle after reset deasserts.
- Reset mid-transaction drops any pending AW/W/AR state and any pending response.
- Write latency: the handshake completing the AW+W pair occurs in cycle N; `bvalid`=1 and the new register value (`led`, `irq`) are visible in N+1.
- Read latency: AR handshake in cycle N gives `rvalid` in N+1. Back-to-back throughput is one read per 2 cycles when `rready` is held high.
- Button latency: a clean pin change held steady moves `stable` after 2 (sync) + DEBOUNCE_CYCLES cycles.
  - The status bit sets 1 cycle later; `irq` rises the same cycle if the bit is masked in.
  - A bounce shorter than DEBOUNCE_CYCLES cycles produces no change.
- `eoi` and a W1C write on the same edge: the union of both clears applies.

## Test plan
- **LED write/read:**
  - Write 0x000000A5 to 0x00 with `wstrb`=0xF; `bvalid` arrives 1 cycle after the handshake with `bresp`=0, and `led`=0xA5.
  - Reading 0x00 returns 0xA5, OKAY.
- **Channel ordering and backpressure:**
  - W presented 3 cycles before AW: `wready` drops after the W handshake, and the commit occurs 1 cycle after the AW handshake.
  - Hold `bready`=0 for 5 cycles: `bvalid` holds and `awready`/`wready` stay 0.
- **Error and strobe:**
  - Read 0x40: returns `rdata`=0, `rresp`=2'b10.
  - Write 0x00 with `wstrb`=0x0: `led` unchanged, `bresp`=0.
- **Debounce (DEBOUNCE_CYCLES=8):**
  - Toggle `btn[2]` with 5-cycle bounces: BTN reads 0 and `irq` stays 0.
  - Hold `btn[2]` high: BTN=0x4 after 10 cycles and IRQ_STATUS=0x4.
  - With MASK=0x4, `irq`=1.
- **Clear paths:**
  - Write 0x4 to 0x08: `irq` falls 1 cycle after the handshake.
  - Repeat the press, then pulse `eoi`: IRQ_STATUS=0.
  - New edge coincident with `eoi`: the bit remains set.
- **Reset mid-operation:** assert `reset` while `rvalid`=1 and a W is latched; all outputs read 0 the next cycle and no register changes.
